// File: rtl/elastic_reg_pipe_pkg.sv
// -----------------------------------------------------------------------------
// elastic_reg_pipe_pkg
// Shared defaults for the elastic register pipe: default data width, default
// stage count and a helper that sizes the occupancy counter.
// No ports (package).
// -----------------------------------------------------------------------------
package elastic_reg_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Bits needed to hold a count in 0..depth (clog2 of depth+1).
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_reg_pipe_if.sv
// -----------------------------------------------------------------------------
// elastic_reg_pipe_if
// Producer and consumer valid/ready handshake bundle of the elastic pipe.
//   in_valid/in_data/in_ready    : producer side
//   out_valid/out_data/out_ready : consumer side
// Modports: slave = the pipe itself, master = whoever drives and drains it.
// -----------------------------------------------------------------------------
interface elastic_reg_pipe_if
   import elastic_reg_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
endinterface

// File: rtl/elastic_reg_pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One valid/data register pair of the elastic pipe.
//   clk, rst      : clock, asynchronous active-low reset
//   flush         : synchronous clear of the valid bit (data holds)
//   up_valid/data : what the upstream neighbour (or producer) offers
//   dn_ready      : downstream stage can take this stage's content
//   v, d          : registered valid/data
//   rdy           : this stage loads on the next edge (empty or draining)
// -----------------------------------------------------------------------------
module pipe_stage
   import elastic_reg_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   output logic             v,
   output logic [WIDTH-1:0] d,
   output logic             rdy
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   assign rdy = !v_q || dn_ready;

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         v_d = 1'b0;
      end else if (rdy) begin
         v_d = up_valid;
         // Bubbles leave the data register untouched to save toggling.
         if (up_valid) d_d = up_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/elastic_reg_pipe.sv
// -----------------------------------------------------------------------------
// elastic_reg_pipe
// DEPTH-stage, WIDTH-bit register pipeline with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   flush     : clear every valid bit on the next edge, drop that cycle's
//               input and output transfers
//   bus       : producer/consumer handshake (slave modport)
//   occupancy : number of valid stages
// -----------------------------------------------------------------------------
module elastic_reg_pipe
   import elastic_reg_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = cnt_w(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   elastic_reg_pipe_if.slave  bus,
   output logic [CNT_W-1:0]   occupancy
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] dn_rdy;
   logic [DEPTH-1:0] up_v;
   logic [WIDTH-1:0] d    [DEPTH];
   logic [WIDTH-1:0] up_d [DEPTH];

   // Ready seen by stage i from below: consumer ready, or any empty stage
   // further down. Computed flat from the valid bits so the ready path is a
   // wide OR rather than a chain threaded through the stage instances.
   always_comb begin
      logic acc;
      dn_rdy = '0;
      acc    = bus.out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         dn_rdy[i] = acc;
         acc       = acc || !v[i];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign up_v[g] = bus.in_valid;
         assign up_d[g] = bus.in_data;
      end else begin : g_body
         assign up_v[g] = v[g-1];
         assign up_d[g] = d[g-1];
      end

      pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .up_valid (up_v[g]),
         .up_data  (up_d[g]),
         .dn_ready (dn_rdy[g]),
         .v        (v[g]),
         .d        (d[g]),
         .rdy      (rdy[g])
      );
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = v[DEPTH-1];
   assign bus.out_data  = d[DEPTH-1];

   // Occupancy is the popcount of the valid bits each stage will hold after
   // the edge, so the registered value always matches the pipe contents.
   logic [CNT_W-1:0] occ_q, occ_d;

   always_comb begin
      occ_d = '0;
      if (!flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] ? up_v[i] : v[i]) occ_d = occ_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) occ_q <= '0;
      else      occ_q <= occ_d;
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_reg_pipe.sv
module tb_elastic_reg_pipe;
   localparam int W = 8;
   localparam int D = 4;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       flush = 1'b0;
   logic [2:0] occupancy;

   elastic_reg_pipe_if #(.WIDTH(W)) bus ();

   elastic_reg_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   int nchk  = 0;
   int nfail = 0;

   // Model: D slots (index D-1 is the output). Each edge, the front item
   // leaves if taken, every item then steps forward if the slot ahead is
   // free, and a new item enters slot 0 if it is free.
   bit         mv [D];
   logic [W-1:0] md [D];
   logic [W-1:0] sb [$];       // accepted, not yet delivered, in order
   logic [W-1:0] dut_log [$];  // what the DUT actually delivered

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mcount();
      int n = 0;
      for (int i = 0; i < D; i++) n += int'(mv[i]);
      return n;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < D; i++) mv[i] = 1'b0;
      sb.delete();
   endtask

   // Drive one cycle's inputs (clock low), then compare against the model.
   task automatic apply(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl);
      bit exp_rdy;
      logic [W-1:0] front;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      flush         = fl;
      #1;
      // An empty slot anywhere, or a draining consumer, makes room at the input.
      exp_rdy = (mcount() < D) || ordy;
      chk("out_valid", bus.out_valid, mv[D-1]);
      if (mv[D-1]) chk("out_data", bus.out_data, md[D-1]);
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("occupancy", occupancy, mcount());
      if (fl) begin
         sb.delete();
      end else begin
         if (bus.out_valid && ordy) begin
            dut_log.push_back(bus.out_data);
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               front = sb.pop_front();
               chk("sb_order", bus.out_data, front);
            end
         end
         if (iv && exp_rdy) sb.push_back(id);
      end
   endtask

   task automatic model_edge();
      if (flush) begin
         for (int i = 0; i < D; i++) mv[i] = 1'b0;
         return;
      end
      if (mv[D-1] && bus.out_ready) mv[D-1] = 1'b0;
      for (int i = D - 2; i >= 0; i--) begin
         if (mv[i] && !mv[i+1]) begin
            mv[i+1] = 1'b1;
            md[i+1] = md[i];
            mv[i]   = 1'b0;
         end
      end
      if (bus.in_valid && !mv[0]) begin
         mv[0] = 1'b1;
         md[0] = bus.in_data;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         apply(1'b0, 8'h00, 1'b1, 1'b0);
         advance();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      model_clear();

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst = 1'b1;
      @(negedge clk);

      // Stream 0x01..0x08 with consumer always ready
      for (int c = 0; c < 12; c++) begin
         apply(c < 8, 8'(c + 1), 1'b1, 1'b0);
         if (c >= 4) begin
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_data", bus.out_data, 32'(c - 3));
         end else begin
            chk("stream_latency", bus.out_valid, 0);
         end
         if (c >= 4 && c <= 8) chk("stream_occ", occupancy, 4);
         advance();
      end
      drain(2);
      chk("stream_count", dut_log.size(), 8);

      // Full stall: four fill, fifth is refused until the consumer drains
      dut_log.delete();
      for (int k = 0; k < 5; k++) begin
         apply(1'b1, 8'(8'hB1 + k), 1'b0, 1'b0);
         if (k == 4) begin
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_occ", occupancy, 4);
         end
         advance();
      end
      apply(1'b1, 8'hB5, 1'b1, 1'b0);
      advance();
      drain(6);
      chk("stall_count", dut_log.size(), 5);
      for (int k = 0; k < 5 && k < dut_log.size(); k++)
         chk("stall_order", dut_log[k], 32'(8'hB1 + k));

      // Bubble collapse under stall
      dut_log.delete();
      apply(1'b1, 8'hA1, 1'b0, 1'b0); advance();
      apply(1'b0, 8'h00, 1'b0, 1'b0); advance();
      apply(1'b0, 8'h00, 1'b0, 1'b0); advance();
      apply(1'b1, 8'hA2, 1'b0, 1'b0); advance();
      for (int k = 0; k < 3; k++) begin
         apply(1'b0, 8'h00, 1'b0, 1'b0); advance();
      end
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      chk("bubble_occ", occupancy, 2);
      chk("bubble_front", bus.out_data, 8'hA1);
      advance();
      drain(4);
      chk("bubble_count", dut_log.size(), 2);
      if (dut_log.size() == 2) chk("bubble_second", dut_log[1], 8'hA2);

      // Flush with three items in flight and an input offered
      dut_log.delete();
      apply(1'b1, 8'hC1, 1'b0, 1'b0); advance();
      apply(1'b1, 8'hC2, 1'b0, 1'b0); advance();
      apply(1'b1, 8'hC3, 1'b0, 1'b0); advance();
      apply(1'b1, 8'hC4, 1'b1, 1'b1);
      chk("flush_in_ready", bus.in_ready, 1);
      advance();
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      chk("flush_occ", occupancy, 0);
      chk("flush_out_valid", bus.out_valid, 0);
      advance();
      drain(6);
      chk("flush_none_out", dut_log.size(), 0);

      // Asynchronous reset between edges
      for (int k = 0; k < 3; k++) begin
         apply(1'b1, 8'(8'hE1 + k), 1'b1, 1'b0); advance();
      end
      bus.in_valid = 1'b0;
      #2 rst = 1'b0;
      model_clear();
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_occ", occupancy, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      #1 rst = 1'b1;
      @(negedge clk);
      dut_log.delete();
      apply(1'b1, 8'hF1, 1'b1, 1'b0); advance();
      for (int c = 1; c <= 4; c++) begin
         apply(1'b0, 8'h00, 1'b1, 1'b0);
         if (c == 4) begin
            chk("arst_latency_valid", bus.out_valid, 1);
            chk("arst_latency_data", bus.out_data, 8'hF1);
         end else begin
            chk("arst_latency_early", bus.out_valid, 0);
         end
         advance();
      end

      // Random traffic against model and scoreboard
      for (int c = 0; c < 10000; c++) begin
         apply($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
               $urandom_range(0, 199) == 0);
         advance();
      end
      drain(D + 2);
      chk("rand_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
